// File: rtl/chirp_gen.sv
// Linear-FM chirp sequencer: steps the NCO frequency word from start_ctrl toward end_ctrl
// (up, down or triangle), with a finite or continuous burst, inter-chirp gaps and stop/abort.
module chirp_gen #(
    parameter int CTRL_W  = 32,
    parameter int RATE_W  = 16,
    parameter int DELAY_W = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [DELAY_W-1:0] delay,
    input  logic [RATE_W-1:0]  prp_rate,
    input  logic [RATE_W-1:0]  inv_rate,
    input  logic [CTRL_W-1:0]  start_ctrl,
    input  logic [CTRL_W-1:0]  end_ctrl,
    input  logic [COUNT_W-1:0] num_chirps,
    output logic               nco_reset,
    output logic [CTRL_W-1:0]  nco_control,
    output logic               busy,
    output logic               chirp_start,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SWEEP_UP = 2'd1;
    localparam logic [1:0] SWEEP_DN = 2'd2;
    localparam logic [1:0] GAP      = 2'd3;

    localparam logic [1:0] MODE_UP  = 2'd0;
    localparam logic [1:0] MODE_DN  = 2'd1;
    localparam logic [1:0] MODE_TRI = 2'd2;
    localparam logic [1:0] MODE_BAD = 2'd3;

    // Result layout for the step functions: {leg_end, clamped_word}.
    function automatic logic [CTRL_W:0] step_up(input logic [CTRL_W-1:0] cur,
                                                input logic [RATE_W-1:0] step,
                                                input logic [CTRL_W-1:0] tgt);
        logic [CTRL_W:0] sum;
        sum = {1'b0, cur} + {{(CTRL_W+1-RATE_W){1'b0}}, step};
        if (sum >= {1'b0, tgt})
            step_up = {1'b1, tgt};
        else
            step_up = {1'b0, sum[CTRL_W-1:0]};
    endfunction

    function automatic logic [CTRL_W:0] step_dn(input logic [CTRL_W-1:0] cur,
                                                input logic [RATE_W-1:0] step,
                                                input logic [CTRL_W-1:0] tgt);
        logic signed [CTRL_W:0] diff;
        logic signed [CTRL_W:0] lim;
        diff = $signed({1'b0, cur}) - $signed({{(CTRL_W+1-RATE_W){1'b0}}, step});
        lim  = $signed({1'b0, tgt});
        if (diff <= lim)
            step_dn = {1'b1, tgt};
        else
            step_dn = {1'b0, diff[CTRL_W-1:0]};
    endfunction

    logic [1:0]         state;
    logic [1:0]         mode_s;
    logic [DELAY_W-1:0] delay_s;
    logic [RATE_W-1:0]  rate_s;
    logic [RATE_W-1:0]  inv_s;
    logic [CTRL_W-1:0]  start_s;
    logic [CTRL_W-1:0]  end_s;
    logic [COUNT_W-1:0] num_s;
    logic [RATE_W-1:0]  presc;
    logic [COUNT_W-1:0] chirp_cnt;
    logic [DELAY_W-1:0] gap_cnt;
    logic               tri_ret;
    logic               leg_done;
    logic               cfg_bad;
    logic [CTRL_W:0]    up_res;
    logic [CTRL_W:0]    dn_res;
    logic [1:0]         sweep_entry;

    always_comb begin
        cfg_bad = 1'b0;
        case (mode)
            MODE_BAD: cfg_bad = 1'b1;
            MODE_DN:  cfg_bad = (start_ctrl <= end_ctrl);
            default:  cfg_bad = (start_ctrl >= end_ctrl);
        endcase
        if (prp_rate == '0)
            cfg_bad = 1'b1;
    end

    assign up_res      = step_up(nco_control, rate_s, end_s);
    assign dn_res      = step_dn(nco_control, rate_s, tri_ret ? start_s : end_s);
    assign sweep_entry = (mode_s == MODE_DN) ? SWEEP_DN : SWEEP_UP;
    assign busy        = (state != IDLE);
    assign nco_reset   = (state == IDLE) || (state == GAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode_s      <= '0;
            delay_s     <= '0;
            rate_s      <= '0;
            inv_s       <= '0;
            start_s     <= '0;
            end_s       <= '0;
            num_s       <= '0;
            presc       <= '0;
            chirp_cnt   <= '0;
            gap_cnt     <= '0;
            tri_ret     <= 1'b0;
            leg_done    <= 1'b0;
            nco_control <= '0;
            chirp_start <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            chirp_start <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            if (state == IDLE) begin
                // stop in the same cycle suppresses the start entirely
                if (start && !stop) begin
                    if (cfg_bad) begin
                        err <= 1'b1;
                    end else begin
                        mode_s      <= mode;
                        delay_s     <= delay;
                        rate_s      <= prp_rate;
                        inv_s       <= inv_rate;
                        start_s     <= start_ctrl;
                        end_s       <= end_ctrl;
                        num_s       <= num_chirps;
                        state       <= (mode == MODE_DN) ? SWEEP_DN : SWEEP_UP;
                        nco_control <= start_ctrl;
                        chirp_start <= 1'b1;
                        presc       <= '0;
                        chirp_cnt   <= '0;
                        tri_ret     <= 1'b0;
                        leg_done    <= 1'b0;
                    end
                end
            end else if (stop) begin
                state    <= IDLE;
                leg_done <= 1'b0;
            end else if (state == GAP) begin
                if (gap_cnt == delay_s - DELAY_W'(1)) begin
                    state       <= sweep_entry;
                    chirp_start <= 1'b1;
                    presc       <= '0;
                    tri_ret     <= 1'b0;
                end else begin
                    gap_cnt <= gap_cnt + DELAY_W'(1);
                end
            end else if (leg_done) begin
                // The end word is shown for one cycle before the burst decision.
                leg_done <= 1'b0;
                if ((num_s != '0) && (chirp_cnt == num_s)) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else if (delay_s == '0) begin
                    state       <= sweep_entry;
                    nco_control <= start_s;
                    chirp_start <= 1'b1;
                    presc       <= '0;
                    tri_ret     <= 1'b0;
                end else begin
                    state       <= GAP;
                    gap_cnt     <= '0;
                    presc       <= '0;
                    nco_control <= start_s;
                end
            end else if (presc != inv_s) begin
                presc <= presc + RATE_W'(1);
            end else begin
                presc <= '0;
                if (state == SWEEP_UP) begin
                    nco_control <= up_res[CTRL_W-1:0];
                    if (up_res[CTRL_W]) begin
                        if (mode_s == MODE_TRI) begin
                            state   <= SWEEP_DN;
                            tri_ret <= 1'b1;
                        end else begin
                            leg_done <= 1'b1;
                            if (chirp_cnt != '1)
                                chirp_cnt <= chirp_cnt + COUNT_W'(1);
                        end
                    end
                end else begin
                    nco_control <= dn_res[CTRL_W-1:0];
                    if (dn_res[CTRL_W]) begin
                        leg_done <= 1'b1;
                        if (chirp_cnt != '1)
                            chirp_cnt <= chirp_cnt + COUNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_chirp_gen.sv
// Directed bench for chirp_gen: hand-computed NCO word sequences, burst control and validation.
module tb_chirp_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop;
    logic [1:0]  mode;
    logic [7:0]  delay;
    logic [15:0] prp_rate, inv_rate;
    logic [31:0] start_ctrl, end_ctrl;
    logic [7:0]  num_chirps;
    logic        nco_reset, busy, chirp_start, done, err;
    logic [31:0] nco_control;

    int n_checks = 0;
    int n_fail   = 0;
    int cs_cnt;

    chirp_gen #(.CTRL_W(32), .RATE_W(16), .DELAY_W(8), .COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .delay(delay),
        .prp_rate(prp_rate), .inv_rate(inv_rate), .start_ctrl(start_ctrl),
        .end_ctrl(end_ctrl), .num_chirps(num_chirps), .nco_reset(nco_reset),
        .nco_control(nco_control), .busy(busy), .chirp_start(chirp_start),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] m, input logic [31:0] s, input logic [31:0] e,
                       input logic [15:0] r, input logic [15:0] iv, input logic [7:0] d,
                       input logic [7:0] n);
        mode = m; start_ctrl = s; end_ctrl = e; prp_rate = r;
        inv_rate = iv; delay = d; num_chirps = n;
    endtask

    // Returns in the first cycle after the accepting edge (cycle k+1).
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        cfg(2'd0, 32'd0, 32'd0, 16'd0, 16'd0, 8'd0, 8'd0);
        #12;
        check("rst_nco", nco_control, 0);
        check("rst_nco_reset", nco_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_pulses", {chirp_start, done, err}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Up burst of two with a two-cycle gap; inputs scrambled after start
        cfg(2'd0, 32'd100, 32'd130, 16'd10, 16'd1, 8'd2, 8'd2);
        do_start();
        cfg(2'd1, 32'd999, 32'd5, 16'd3, 16'd0, 8'd0, 8'd0);
        cs_cnt = 0;
        for (int c = 1; c <= 17; c++) begin
            if (c > 1) @(negedge clk);
            cs_cnt += int'(chirp_start);
            case (c)
                1:  begin check("t1_nco_k1", nco_control, 100); check("t1_cs_k1", chirp_start, 1);
                          check("t1_busy_k1", busy, 1); check("t1_rst_k1", nco_reset, 0); end
                2:  check("t1_nco_k2", nco_control, 100);
                3:  check("t1_nco_k3", nco_control, 110);
                5:  check("t1_nco_k5", nco_control, 120);
                7:  begin check("t1_nco_k7", nco_control, 130); check("t1_rst_k7", nco_reset, 0); end
                8:  begin check("t1_rst_k8", nco_reset, 1); check("t1_nco_k8", nco_control, 100); end
                9:  check("t1_rst_k9", nco_reset, 1);
                10: begin check("t1_cs_k10", chirp_start, 1); check("t1_rst_k10", nco_reset, 0);
                          check("t1_nco_k10", nco_control, 100); end
                12: check("t1_nco_k12", nco_control, 110);
                16: begin check("t1_nco_k16", nco_control, 130); check("t1_done_k16", done, 0); end
                17: begin check("t1_done_k17", done, 1); check("t1_busy_k17", busy, 0);
                          check("t1_rst_k17", nco_reset, 1); check("t1_hold_k17", nco_control, 130); end
                default: ;
            endcase
        end
        check("t1_cs_total", cs_cnt, 2);
        @(negedge clk);
        check("t1_done_pulse", done, 0);

        // Clamp at end word, never overshoot
        cfg(2'd0, 32'd0, 32'd25, 16'd10, 16'd0, 8'd0, 8'd1);
        do_start();
        check("cl_k1", nco_control, 0);
        @(negedge clk); check("cl_k2", nco_control, 10);
        @(negedge clk); check("cl_k3", nco_control, 20);
        @(negedge clk); check("cl_k4", nco_control, 25);
        @(negedge clk); check("cl_done", done, 1); check("cl_hold", nco_control, 25);

        // Triangle: up then return to start, single chirp_start
        cfg(2'd2, 32'd0, 32'd20, 16'd10, 16'd0, 8'd0, 8'd1);
        do_start();
        cs_cnt = int'(chirp_start);
        check("tr_k1", nco_control, 0);
        @(negedge clk); cs_cnt += int'(chirp_start); check("tr_k2", nco_control, 10);
        @(negedge clk); cs_cnt += int'(chirp_start); check("tr_k3", nco_control, 20);
        @(negedge clk); cs_cnt += int'(chirp_start); check("tr_k4", nco_control, 10);
        check("tr_rst_k4", nco_reset, 0);
        @(negedge clk); cs_cnt += int'(chirp_start); check("tr_k5", nco_control, 0);
        check("tr_done_k5", done, 0);
        @(negedge clk); check("tr_done_k6", done, 1);
        check("tr_cs_total", cs_cnt, 1);

        // Down mode
        cfg(2'd1, 32'd50, 32'd20, 16'd15, 16'd0, 8'd0, 8'd1);
        do_start();
        check("dn_k1", nco_control, 50);
        @(negedge clk); check("dn_k2", nco_control, 35);
        @(negedge clk); check("dn_k3", nco_control, 20);
        @(negedge clk); check("dn_done", done, 1);

        // Validation rejects
        cfg(2'd0, 32'd40, 32'd40, 16'd5, 16'd0, 8'd0, 8'd1);
        do_start();
        check("v_eq_err", err, 1); check("v_eq_busy", busy, 0);
        @(negedge clk); check("v_eq_err_pulse", err, 0);
        cfg(2'd0, 32'd10, 32'd40, 16'd0, 16'd0, 8'd0, 8'd1);
        do_start();
        check("v_rate0_err", err, 1); check("v_rate0_busy", busy, 0);
        cfg(2'd3, 32'd10, 32'd40, 16'd5, 16'd0, 8'd0, 8'd1);
        do_start();
        check("v_mode3_err", err, 1);
        cfg(2'd1, 32'd10, 32'd40, 16'd5, 16'd0, 8'd0, 8'd1);
        do_start();
        check("v_dn_err", err, 1); check("v_dn_busy", busy, 0);

        // Continuous back-to-back chirps, then stop mid-sweep
        cfg(2'd0, 32'd0, 32'd20, 16'd10, 16'd0, 8'd0, 8'd0);
        do_start();
        check("co_cs_k1", chirp_start, 1);
        @(negedge clk); check("co_k2", nco_control, 10);
        @(negedge clk); check("co_k3", nco_control, 20);
        @(negedge clk); check("co_cs_k4", chirp_start, 1); check("co_k4", nco_control, 0);
        repeat (3) @(negedge clk);
        check("co_cs_k7", chirp_start, 1); check("co_busy_k7", busy, 1);
        @(negedge clk); check("co_k8", nco_control, 10);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("st_busy", busy, 0); check("st_rst", nco_reset, 1);
        check("st_done", done, 0); check("st_hold", nco_control, 10);
        check("st_cs", chirp_start, 0);

        // Simultaneous start and stop in IDLE
        cfg(2'd0, 32'd0, 32'd20, 16'd10, 16'd0, 8'd0, 8'd1);
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        check("ss_busy", busy, 0); check("ss_cs", chirp_start, 0);

        // Asynchronous reset between edges
        cfg(2'd0, 32'd100, 32'd130, 16'd10, 16'd1, 8'd0, 8'd2);
        do_start();
        repeat (3) @(negedge clk);
        check("ar_pre_nco", nco_control, 110);
        #2 rst = 1'b1;
        #1;
        check("ar_nco", nco_control, 0); check("ar_rst", nco_reset, 1); check("ar_busy", busy, 0);
        @(negedge clk); rst = 1'b0;
        do_start();
        check("ar2_k1", nco_control, 100); check("ar2_cs", chirp_start, 1);
        @(negedge clk); @(negedge clk);
        check("ar2_k3", nco_control, 110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chirp_gen.md
Name: chirp_gen

Overview:
Parametrised linear-FM chirp sequencer driving the NCO frequency-control word and NCO reset. It generalises the fixed 32-bit free-running sweep with configurable widths, up/down/triangle modes, and end-point clamping. It adds a start/stop handshake, a finite or continuous burst count, and config validation. It sits between the control register bank and the NCO.

Parameters:
CTRL_W, 32, width of start/end/nco_control words
RATE_W, 16, width of step (prp_rate) and prescaler (inv_rate)
DELAY_W, 8, width of inter-chirp gap counter
COUNT_W, 8, width of burst chirp counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin burst; sampled only in IDLE
stop  in  1  abort burst; sampled in every state
mode  in  2  00 up, 01 down, 10 triangle, 11 illegal
delay  in  DELAY_W  gap cycles between chirps (NCO held in reset)
prp_rate  in  RATE_W  frequency step per update
inv_rate  in  RATE_W  prescaler; one update every inv_rate+1 cycles
start_ctrl  in  CTRL_W  chirp start word
end_ctrl  in  CTRL_W  chirp end/turn-around word
num_chirps  in  COUNT_W  chirps per burst; 0 = continuous until stop
nco_reset  out  1  NCO phase reset/hold
nco_control  out  CTRL_W  NCO frequency control word
busy  out  1  high in every non-IDLE state
chirp_start  out  1  one-cycle pulse at the start of each chirp
done  out  1  one-cycle pulse on natural burst completion
err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset (async): state IDLE, nco_control=0, nco_reset=1, busy=0, chirp_start=0, done=0, err=0, all counters 0.
- States: IDLE, SWEEP_UP, SWEEP_DN, GAP.
- Config latch: every input except start/stop is captured into shadow registers on an accepted start. Input changes mid-burst have no effect.
- Validation on start in IDLE. Reject (err=1 next cycle, stay IDLE) if any of:
  - mode=11;
  - prp_rate=0;
  - up or triangle with start_ctrl>=end_ctrl;
  - down with start_ctrl<=end_ctrl.
- Start priority: stop and start in the same cycle -> stop wins, nothing starts. start while busy is ignored.
- Accepted start at edge k: at k+1 the block enters SWEEP_UP (modes 00/10) or SWEEP_DN (mode 01). Outputs at k+1: nco_control=start_ctrl, nco_reset=0, chirp_start=1, busy=1. Prescaler and chirp counter cleared.
- Prescaler:
  - increments each sweep cycle;
  - at prescaler==inv_rate it clears and an update is applied;
  - cleared on every state entry.
- Update arithmetic is done in CTRL_W+1 bits; no wrap-around.
- SWEEP_UP update: target is end_ctrl (up mode, or the first leg of triangle).
  - If nco_control+prp_rate >= end_ctrl: nco_control=end_ctrl and the leg ends.
  - Else nco_control += prp_rate.
- SWEEP_DN update: target is end_ctrl in down mode, start_ctrl on the triangle return leg.
  - If nco_control-prp_rate <= target (signed-extended compare): nco_control=target and the leg ends.
  - Else nco_control -= prp_rate.
- Leg end (edge where the clamp value is written):
  - Triangle first leg: next state SWEEP_DN, no chirp_start, nco_reset stays 0.
  - Otherwise the chirp is complete; the chirp counter increments at that edge.
- After a completed chirp:
  - If num_chirps!=0 and the count reaches num_chirps: next edge IDLE, done=1, nco_reset=1. nco_control holds the last value. No gap after the final chirp.
  - Else if delay=0: next edge re-enters the sweep directly with nco_control=start_ctrl and chirp_start=1.
  - Else GAP for exactly delay cycles: nco_reset=1, nco_control=start_ctrl. Then the sweep is entered with chirp_start=1 and nco_reset=0.
- Continuous mode (num_chirps=0): the chirp counter saturates and never terminates the burst.
- stop in any non-IDLE state: next edge IDLE, nco_reset=1, busy=0. done and chirp_start are not asserted. nco_control holds its value.
- IDLE: nco_reset=1. All pulse outputs are low except as specified above.

Test Plan:
- Up, burst of 2: start=100, end=130, step=10, inv_rate=1, delay=2, num=2, start at edge k.
  - nco_control: 100@k+1, 110@k+3, 120@k+5, 130@k+7.
  - nco_reset=1 @k+8..k+9.
  - chirp_start @k+10; 130 @k+16.
  - done @k+17, busy=0.
- Clamp: start=0, end=25, step=10, inv_rate=0, num=1 -> 0, 10, 20, 25 on consecutive cycles, then done. Never 30.
- Triangle: start=0, end=20, step=10, inv_rate=0, num=1 -> 0, 10, 20, 10, 0. Single chirp_start; done the cycle after 0.
- Down and validation:
  - mode=01, start=50, end=20, step=15 -> 50, 35, 20, done.
  - mode=00 with start=end -> err pulse, busy stays 0.
  - prp_rate=0 -> err pulse, busy stays 0.
- Continuous + stop: num=0, delay=0 -> back-to-back chirps with chirp_start each time. stop mid-sweep -> IDLE next cycle, nco_reset=1, no done. Simultaneous start+stop in IDLE -> no start.
- Async reset mid-sweep: assert rst between edges -> outputs reach reset values immediately without a clock edge. After release, a new start behaves as a first start.
